// File: rtl/rv32i_types.sv
// Shared types for the RAT: the ROB commit bus and a per-source read result.
// ROB_DEPTH_BITS must equal the depth_bits parameter of regfile_rat and of the ROB instance.
package rv32i_types;

   localparam int ROB_DEPTH_BITS = 5;

   typedef struct packed {
      logic                      ready;
      logic [4:0]                rd_addr;
      logic [31:0]               rd_data;
      logic [ROB_DEPTH_BITS-1:0] rob_id;
   } rob_reg_data_bus_t;

   typedef struct packed {
      logic [31:0]               v;
      logic                      ready;
      logic [ROB_DEPTH_BITS-1:0] tag;
   } rat_read_t;

endpackage

// File: rtl/rat_read_port.sv
// One source lookup: x0 forcing and, with RAT_COMMIT_BYPASS_EN, same-cycle commit bypass.
// Purely combinational; no backpressure.
module rat_read_port
   import rv32i_types::*;
#(
   parameter int depth_bits = 5
) (
   input  logic [4:0]            addr,
   input  logic [31:0]           reg_v,
   input  logic                  reg_busy,
   input  logic [depth_bits-1:0] reg_tag,
   input  rob_reg_data_bus_t     commit_bus,
   output rat_read_t             rd
);

`ifdef RAT_COMMIT_BYPASS_EN
   logic commit_hit;
   // Only a commit from the producer the source is waiting on may be forwarded.
   assign commit_hit = commit_bus.ready && (commit_bus.rd_addr == addr) && reg_busy &&
                       (reg_tag == depth_bits'(commit_bus.rob_id));
`else
   rob_reg_data_bus_t unused_commit;
   assign unused_commit = commit_bus;
`endif

   always_comb begin
      rd.v     = reg_v;
      rd.ready = !reg_busy;
      rd.tag   = reg_busy ? ROB_DEPTH_BITS'(reg_tag) : '0;
`ifdef RAT_COMMIT_BYPASS_EN
      if (commit_hit) begin
         rd.v     = commit_bus.rd_data;
         rd.ready = 1'b1;
         rd.tag   = '0;
      end
`endif
      if (addr == 5'd0) begin
         rd.v     = '0;
         rd.ready = 1'b1;
         rd.tag   = '0;
      end
   end

endmodule

// File: rtl/regfile_rat.sv
// Architectural register file plus rename alias table (busy bit and ROB tag per register).
// Reads are zero-latency; updates land on the next clk edge; no backpressure. Optional macro: RAT_COMMIT_BYPASS_EN.
module regfile_rat
   import rv32i_types::*;
#(
   parameter int depth_bits = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rename_valid,
   input  logic [4:0]            rename_rd_addr,
   input  logic [depth_bits-1:0] rename_rob_id,
   input  logic [4:0]            rs1_addr,
   input  logic [4:0]            rs2_addr,
   output logic [31:0]           rs1_v,
   output logic [31:0]           rs2_v,
   output logic                  rs1_ready,
   output logic                  rs2_ready,
   output logic [depth_bits-1:0] rs1_tag,
   output logic [depth_bits-1:0] rs2_tag,
   input  rob_reg_data_bus_t     commit_bus,
   input  logic                  flush
);

   logic [31:0]           regs_q [32];
   logic [31:0]           regs_d [32];
   logic                  busy_q [32];
   logic                  busy_d [32];
   logic [depth_bits-1:0] tag_q  [32];
   logic [depth_bits-1:0] tag_d  [32];

   logic commit_en;
   logic rename_en;

   assign commit_en = commit_bus.ready && (commit_bus.rd_addr != 5'd0);
   assign rename_en = rename_valid && (rename_rd_addr != 5'd0);

   // Order matters: commit, then rename (newest mapping wins), then flush clears all mappings.
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      tag_d  = tag_q;
      if (commit_en) begin
         regs_d[commit_bus.rd_addr] = commit_bus.rd_data;
         if (tag_q[commit_bus.rd_addr] == depth_bits'(commit_bus.rob_id)) begin
            busy_d[commit_bus.rd_addr] = 1'b0;
            tag_d[commit_bus.rd_addr]  = '0;
         end
      end
      if (rename_en) begin
         busy_d[rename_rd_addr] = 1'b1;
         tag_d[rename_rd_addr]  = rename_rob_id;
      end
      if (flush) begin
         for (int i = 0; i < 32; i++) begin
            busy_d[i] = 1'b0;
            tag_d[i]  = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= '0;
            busy_q[i] <= 1'b0;
            tag_q[i]  <= '0;
         end
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
         tag_q  <= tag_d;
      end
   end

   rat_read_t rd1;
   rat_read_t rd2;

   rat_read_port #(.depth_bits(depth_bits)) u_rs1 (
      .addr       (rs1_addr),
      .reg_v      (regs_q[rs1_addr]),
      .reg_busy   (busy_q[rs1_addr]),
      .reg_tag    (tag_q[rs1_addr]),
      .commit_bus (commit_bus),
      .rd         (rd1)
   );

   rat_read_port #(.depth_bits(depth_bits)) u_rs2 (
      .addr       (rs2_addr),
      .reg_v      (regs_q[rs2_addr]),
      .reg_busy   (busy_q[rs2_addr]),
      .reg_tag    (tag_q[rs2_addr]),
      .commit_bus (commit_bus),
      .rd         (rd2)
   );

   assign rs1_v     = rd1.v;
   assign rs1_ready = rd1.ready;
   assign rs1_tag   = depth_bits'(rd1.tag);
   assign rs2_v     = rd2.v;
   assign rs2_ready = rd2.ready;
   assign rs2_tag   = depth_bits'(rd2.tag);

endmodule

// File: tb/tb_regfile_rat.sv
// Self-checking bench for regfile_rat: directed scenarios plus randomized traffic against an array model.
module tb_regfile_rat;
   import rv32i_types::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              rename_valid;
   logic [4:0]        rename_rd_addr;
   logic [4:0]        rename_rob_id;
   logic [4:0]        rs1_addr, rs2_addr;
   logic [31:0]       rs1_v, rs2_v;
   logic              rs1_ready, rs2_ready;
   logic [4:0]        rs1_tag, rs2_tag;
   rob_reg_data_bus_t commit_bus;
   logic              flush;

   int tests = 0;
   int failed = 0;

   regfile_rat #(.depth_bits(5)) dut (
      .clk            (clk),
      .rst            (rst),
      .rename_valid   (rename_valid),
      .rename_rd_addr (rename_rd_addr),
      .rename_rob_id  (rename_rob_id),
      .rs1_addr       (rs1_addr),
      .rs2_addr       (rs2_addr),
      .rs1_v          (rs1_v),
      .rs2_v          (rs2_v),
      .rs1_ready      (rs1_ready),
      .rs2_ready      (rs2_ready),
      .rs1_tag        (rs1_tag),
      .rs2_tag        (rs2_tag),
      .commit_bus     (commit_bus),
      .flush          (flush)
   );

   always #5 clk = ~clk;

   // Reference model: architectural value, pending flag and producer tag per register.
   logic [31:0] m_val [32];
   bit          m_pend [32];
   logic [4:0]  m_prod [32];

   function automatic logic [37:0] exp_read(input logic [4:0] a);
      if (a == 5'd0) return {32'd0, 1'b1, 5'd0};
`ifdef RAT_COMMIT_BYPASS_EN
      if (commit_bus.ready && commit_bus.rd_addr == a && m_pend[a] && m_prod[a] == commit_bus.rob_id)
         return {commit_bus.rd_data, 1'b1, 5'd0};
`endif
      if (m_pend[a]) return {m_val[a], 1'b0, m_prod[a]};
      return {m_val[a], 1'b1, 5'd0};
   endfunction

   task automatic model_update();
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            m_val[i] = 0; m_pend[i] = 0; m_prod[i] = 0;
         end
         return;
      end
      if (commit_bus.ready && commit_bus.rd_addr != 0) begin
         m_val[commit_bus.rd_addr] = commit_bus.rd_data;
         if (m_prod[commit_bus.rd_addr] == commit_bus.rob_id) begin
            m_pend[commit_bus.rd_addr] = 0;
            m_prod[commit_bus.rd_addr] = 0;
         end
      end
      if (rename_valid && rename_rd_addr != 0) begin
         m_pend[rename_rd_addr] = 1;
         m_prod[rename_rd_addr] = rename_rob_id;
      end
      if (flush) begin
         for (int i = 0; i < 32; i++) begin
            m_pend[i] = 0; m_prod[i] = 0;
         end
      end
   endtask

   task automatic idle();
      rst = 0; rename_valid = 0; rename_rd_addr = 0; rename_rob_id = 0;
      commit_bus = '0; flush = 0;
   endtask

   // Clock edge, model advance with the inputs that were applied, then return inputs to idle.
   task automatic step();
      @(posedge clk);
      #1;
      model_update();
      idle();
   endtask

   task automatic do_rename(input logic [4:0] rd, input logic [4:0] id);
      rename_valid = 1; rename_rd_addr = rd; rename_rob_id = id;
   endtask

   task automatic do_commit(input logic [4:0] rd, input logic [4:0] id, input logic [31:0] d);
      commit_bus.ready = 1; commit_bus.rd_addr = rd; commit_bus.rob_id = id; commit_bus.rd_data = d;
   endtask

   task automatic test_reset();
      idle();
      rst = 1;
      do_rename(5'd3, 5'd7);
      do_commit(5'd3, 5'd7, 32'hCAFE0000);
      flush = 1;
      step();
      for (int a = 0; a < 32; a++) begin
         rs1_addr = 5'(a); rs2_addr = 5'(31 - a);
         #1;
         tests++;
         if ({rs1_v, rs1_ready, rs1_tag} !== {32'd0, 1'b1, 5'd0}) begin
            failed++;
            $display("FAIL reset_rs1 x%0d got v=%h rdy=%b tag=%0d need v=0 rdy=1 tag=0", a, rs1_v, rs1_ready, rs1_tag);
         end
         tests++;
         if ({rs2_v, rs2_ready, rs2_tag} !== {32'd0, 1'b1, 5'd0}) begin
            failed++;
            $display("FAIL reset_rs2 x%0d got v=%h rdy=%b tag=%0d need v=0 rdy=1 tag=0", 31 - a, rs2_v, rs2_ready, rs2_tag);
         end
      end
   endtask

   task automatic test_rename_commit();
      do_rename(5'd5, 5'd3);
      step();
      rs1_addr = 5; #1;
      tests++;
      if ({rs1_ready, rs1_tag} !== {1'b0, 5'd3}) begin
         failed++; $display("FAIL rename_x5 got rdy=%b tag=%0d need rdy=0 tag=3", rs1_ready, rs1_tag);
      end
      do_commit(5'd5, 5'd3, 32'hDEADBEEF);
      step();
      #1;
      tests++;
      if ({rs1_v, rs1_ready, rs1_tag} !== {32'hDEADBEEF, 1'b1, 5'd0}) begin
         failed++; $display("FAIL commit_x5 got v=%h rdy=%b tag=%0d need v=deadbeef rdy=1 tag=0", rs1_v, rs1_ready, rs1_tag);
      end
   endtask

   task automatic test_stale_commit();
      do_rename(5'd7, 5'd2); step();
      do_rename(5'd7, 5'd9); step();
      do_commit(5'd7, 5'd2, 32'h11); step();
      rs2_addr = 7; #1;
      tests++;
      if ({rs2_v, rs2_ready, rs2_tag} !== {32'h11, 1'b0, 5'd9}) begin
         failed++; $display("FAIL stale_commit_x7 got v=%h rdy=%b tag=%0d need v=11 rdy=0 tag=9", rs2_v, rs2_ready, rs2_tag);
      end
   endtask

   task automatic test_same_cycle();
      do_rename(5'd4, 5'd6);
      do_commit(5'd4, 5'd1, 32'h22);
      rs1_addr = 4; #1;
      tests++;
      if ({rs1_v, rs1_ready, rs1_tag} !== {32'd0, 1'b1, 5'd0}) begin
         failed++; $display("FAIL same_cycle_pre got v=%h rdy=%b tag=%0d need v=0 rdy=1 tag=0", rs1_v, rs1_ready, rs1_tag);
      end
      step(); #1;
      tests++;
      if ({rs1_v, rs1_ready, rs1_tag} !== {32'h22, 1'b0, 5'd6}) begin
         failed++; $display("FAIL same_cycle_post got v=%h rdy=%b tag=%0d need v=22 rdy=0 tag=6", rs1_v, rs1_ready, rs1_tag);
      end
   endtask

   task automatic test_flush_wrap();
      do_rename(5'd8, 5'd31); step();
      do_rename(5'd9, 5'd0); step();
      rs1_addr = 8; rs2_addr = 9; #1;
      tests++;
      if ({rs1_ready, rs1_tag, rs2_ready, rs2_tag} !== {1'b0, 5'd31, 1'b0, 5'd0}) begin
         failed++; $display("FAIL wrap_tags got x8 rdy=%b tag=%0d x9 rdy=%b tag=%0d need 0/31 0/0", rs1_ready, rs1_tag, rs2_ready, rs2_tag);
      end
      flush = 1; do_rename(5'd10, 5'd1);
      step(); #1;
      tests++;
      if ({rs1_ready, rs1_tag, rs2_ready, rs2_tag} !== {1'b1, 5'd0, 1'b1, 5'd0}) begin
         failed++; $display("FAIL flush_x8_x9 got rdy=%b/%b tag=%0d/%0d need rdy=1/1 tag=0/0", rs1_ready, rs2_ready, rs1_tag, rs2_tag);
      end
      rs1_addr = 10; #1;
      tests++;
      if ({rs1_ready, rs1_tag} !== {1'b1, 5'd0}) begin
         failed++; $display("FAIL flush_x10 got rdy=%b tag=%0d need rdy=1 tag=0", rs1_ready, rs1_tag);
      end
   endtask

   task automatic test_bypass();
      do_rename(5'd6, 5'd4); step();
      do_commit(5'd6, 5'd4, 32'h55);
      rs1_addr = 6; #1;
      tests++;
`ifdef RAT_COMMIT_BYPASS_EN
      if ({rs1_v, rs1_ready, rs1_tag} !== {32'h55, 1'b1, 5'd0}) begin
         failed++; $display("FAIL bypass_x6 got v=%h rdy=%b tag=%0d need v=55 rdy=1 tag=0", rs1_v, rs1_ready, rs1_tag);
      end
`else
      if ({rs1_ready, rs1_tag} !== {1'b0, 5'd4}) begin
         failed++; $display("FAIL nobypass_x6 got rdy=%b tag=%0d need rdy=0 tag=4", rs1_ready, rs1_tag);
      end
`endif
      step(); #1;
      tests++;
      if ({rs1_v, rs1_ready, rs1_tag} !== {32'h55, 1'b1, 5'd0}) begin
         failed++; $display("FAIL resolve_x6 got v=%h rdy=%b tag=%0d need v=55 rdy=1 tag=0", rs1_v, rs1_ready, rs1_tag);
      end
   endtask

   task automatic test_random();
      logic [37:0] e1, e2;
      for (int c = 0; c < 400; c++) begin
         idle();
         rs1_addr = 5'($urandom_range(0, 9));
         rs2_addr = 5'($urandom_range(0, 9));
         if ($urandom_range(0, 1) == 1) do_rename(5'($urandom_range(0, 9)), 5'($urandom));
         if ($urandom_range(0, 1) == 1) begin
            logic [4:0] rd;
            rd = 5'($urandom_range(0, 9));
            do_commit(rd, ($urandom_range(0, 3) != 0) ? m_prod[rd] : 5'($urandom), $urandom);
         end
         if ($urandom_range(0, 24) == 0) flush = 1;
         #1;
         e1 = exp_read(rs1_addr);
         e2 = exp_read(rs2_addr);
         tests++;
         if ({rs1_v, rs1_ready, rs1_tag} !== e1) begin
            failed++; $display("FAIL rand_rs1 cyc=%0d x%0d got %h need %h", c, rs1_addr, {rs1_v, rs1_ready, rs1_tag}, e1);
         end
         tests++;
         if ({rs2_v, rs2_ready, rs2_tag} !== e2) begin
            failed++; $display("FAIL rand_rs2 cyc=%0d x%0d got %h need %h", c, rs2_addr, {rs2_v, rs2_ready, rs2_tag}, e2);
         end
         step();
      end
   endtask

   task automatic test_reset_mid();
      do_rename(5'd12, 5'd5); step();
      do_commit(5'd13, 5'd0, 32'h77); step();
      rst = 1; do_rename(5'd14, 5'd2); do_commit(5'd13, 5'd0, 32'h99);
      step();
      rs1_addr = 12; rs2_addr = 13; #1;
      tests++;
      if ({rs1_v, rs1_ready, rs1_tag} !== {32'd0, 1'b1, 5'd0}) begin
         failed++; $display("FAIL rst_mid_x12 got v=%h rdy=%b tag=%0d need v=0 rdy=1 tag=0", rs1_v, rs1_ready, rs1_tag);
      end
      tests++;
      if ({rs2_v, rs2_ready, rs2_tag} !== {32'd0, 1'b1, 5'd0}) begin
         failed++; $display("FAIL rst_mid_x13 got v=%h rdy=%b tag=%0d need v=0 rdy=1 tag=0", rs2_v, rs2_ready, rs2_tag);
      end
      rs1_addr = 14; #1;
      tests++;
      if ({rs1_ready, rs1_tag} !== {1'b1, 5'd0}) begin
         failed++; $display("FAIL rst_mid_x14 got rdy=%b tag=%0d need rdy=1 tag=0", rs1_ready, rs1_tag);
      end
   endtask

   initial begin
      idle();
      rs1_addr = 0; rs2_addr = 0;
      test_reset();
      test_rename_commit();
      test_stale_commit();
      test_same_cycle();
      test_flush_wrap();
      test_bypass();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout after %0d tests", tests);
      $fatal(1, "timeout");
   end

endmodule
